// File: rtl/demux4_reg.sv
// demux4_reg: 1-to-4 registered demultiplexer with valid/ready handshakes.
// One holding register steers each input beat to channel a..d selected by i_sel.
//
// Parameters:
//   WIDTH      data width of the input and of each output channel
//   CNT_WIDTH  width of each per-channel drain counter (DEMUX4_CNT_EN only)
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_valid    input beat valid
//   o_ready    block accepts a beat this cycle (combinational from i_ready)
//   i_data     input beat data
//   i_sel      destination channel: 0->a, 1->b, 2->c, 3->d
//   o_valid    per-channel valid, bit k = channel k
//   i_ready    per-channel sink ready, bit k = channel k
//   o_a..o_d   channel data, zero whenever the channel is not valid
//
// Optional build macro DEMUX4_CNT_EN adds per-channel drain counters:
//   i_cnt_clr  synchronous clear of all counters, wins over a same-cycle drain
//   o_cnt      channel k count at bits [k*CNT_WIDTH +: CNT_WIDTH]

module demux4_reg #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_sel,
    output logic [3:0]       o_valid,
    input  logic [3:0]       i_ready,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_c,
    output logic [WIDTH-1:0] o_d
`ifdef DEMUX4_CNT_EN
    ,
    input  logic                   i_cnt_clr,
    output logic [4*CNT_WIDTH-1:0] o_cnt
`endif
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_sel;

    logic             w_drain;
    logic             w_accept;
    logic [3:0]       w_valid;

    // A held beat waits only on the ready of its own sink.
    assign w_drain  = r_full && i_ready[r_sel];

    // Room exists when empty or when the held beat leaves at this edge.
    assign o_ready  = i_rst_n && (!r_full || i_ready[r_sel]);
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_sel  <= 2'd0;
        end else if (w_accept) begin
            // Covers drain+accept too: the new beat replaces the old one.
            r_full <= 1'b1;
            r_data <= i_data;
            r_sel  <= i_sel;
        end else if (w_drain) begin
            r_full <= 1'b0;
        end
    end

    always_comb begin
        w_valid = 4'b0000;
        if (r_full) begin
            unique case (r_sel)
                2'd0: w_valid = 4'b0001;
                2'd1: w_valid = 4'b0010;
                2'd2: w_valid = 4'b0100;
                2'd3: w_valid = 4'b1000;
                default: w_valid = 4'b0000;
            endcase
        end
    end

    assign o_valid = w_valid;

    always_comb begin
        o_a = '0;
        o_b = '0;
        o_c = '0;
        o_d = '0;
        if (w_valid[0]) o_a = r_data;
        if (w_valid[1]) o_b = r_data;
        if (w_valid[2]) o_c = r_data;
        if (w_valid[3]) o_d = r_data;
    end

`ifdef DEMUX4_CNT_EN
    logic [3:0][CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt[r_sel] <= r_cnt[r_sel] + CNT_WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_demux4_reg.sv
// tb_demux4_reg: directed and randomized checks of demux4_reg.
// Random traffic is compared against a one-slot queue model of the block.

module tb_demux4_reg;

    localparam int W  = 8;
    localparam int CW = 2;
    localparam int VW = 1 + 4 + 4 * W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         vin;
    logic         oready;
    logic [W-1:0] din;
    logic [1:0]   sel;
    logic [3:0]   ovalid;
    logic [3:0]   rdy;
    logic [W-1:0] oa, ob, oc, od;
`ifdef DEMUX4_CNT_EN
    logic          clr;
    logic [4*CW-1:0] cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   s;
    } beat_t;

    always #5 clk = ~clk;

    demux4_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (vin),
        .o_ready (oready),
        .i_data  (din),
        .i_sel   (sel),
        .o_valid (ovalid),
        .i_ready (rdy),
        .o_a     (oa),
        .o_b     (ob),
        .o_c     (oc),
        .o_d     (od)
`ifdef DEMUX4_CNT_EN
        ,
        .i_cnt_clr (clr),
        .o_cnt     (cnt)
`endif
    );

    task automatic test_reset();
        logic [VW-1:0] got;
        rst_n = 1'b0;
        vin   = 1'b1;
        din   = 8'hA5;
        sel   = 2'd2;
        rdy   = 4'hF;
`ifdef DEMUX4_CNT_EN
        clr   = 1'b0;
`endif
        #3;
        for (int i = 0; i < 3; i++) begin
            got = {oready, ovalid, oa, ob, oc, od};
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got %h exp 0", i, got);
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        vin   = 1'b0;
        #1;
        checks++;
        if (oready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release o_ready got %b exp 1", oready);
        end
`ifdef DEMUX4_CNT_EN
        checks++;
        if (cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt got %h exp 0", cnt);
        end
`endif
    endtask

    task automatic test_routing();
        logic [VW-1:0] got, exp;
        logic [W-1:0]  ch [4];
        rdy = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 4) begin
                vin = 1'b1;
                din = W'(i + 1);
                sel = 2'(i);
            end else begin
                vin = 1'b0;
            end
            #1;
            if (i > 0) begin
                for (int k = 0; k < 4; k++) ch[k] = '0;
                if (i < 5) ch[i-1] = W'(i);
                exp = {1'b1, (i < 5) ? 4'(1 << (i - 1)) : 4'b0000,
                       ch[0], ch[1], ch[2], ch[3]};
                got = {oready, ovalid, oa, ob, oc, od};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL routing step%0d got %h exp %h", i, got, exp);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] got, exp;
        rdy = 4'b1011;
        @(negedge clk);
        vin = 1'b1;
        din = 8'h33;
        sel = 2'd2;
        exp = {1'b0, 4'b0100, 8'h00, 8'h00, 8'h33, 8'h00};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din = 8'h44;
            sel = 2'd3;
            #1;
            got = {oready, ovalid, oa, ob, oc, od};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bp_hold cyc%0d got %h exp %h", i, got, exp);
            end
        end
        @(negedge clk);
        rdy = 4'b1111;
        #1;
        checks++;
        if (oready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release o_ready got %b exp 1", oready);
        end
        @(negedge clk);
        vin = 1'b0;
        #1;
        exp = {1'b1, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h44};
        got = {oready, ovalid, oa, ob, oc, od};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL bp_next got %h exp %h", got, exp);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ovalid !== 4'b0000) begin
            errors++;
            $display("FAIL bp_empty o_valid got %b exp 0000", ovalid);
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] got, exp;
        rdy = 4'b0000;
        @(negedge clk);
        vin = 1'b1;
        din = 8'h55;
        sel = 2'd1;
        @(negedge clk);
        vin = 1'b0;
        #1;
        exp = {1'b0, 4'b0010, 8'h00, 8'h55, 8'h00, 8'h00};
        got = {oready, ovalid, oa, ob, oc, od};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rmid_held got %h exp %h", got, exp);
        end
        #1;
        rst_n = 1'b0;
        #1;
        got = {oready, ovalid, oa, ob, oc, od};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL rmid_async got %h exp 0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rdy   = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ovalid !== 4'b0000) begin
                errors++;
                $display("FAIL rmid_ghost cyc%0d o_valid got %b exp 0000", i, ovalid);
            end
        end
    endtask

`ifdef DEMUX4_CNT_EN
    task automatic test_counters();
        logic [1:0] seq [6];
        logic [4*CW-1:0] exp;
        seq = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
        rdy = 4'hF;
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vin = 1'b1;
            din = W'($urandom);
            sel = seq[i];
        end
        @(negedge clk);
        vin = 1'b0;
        @(negedge clk);
        #1;
        exp = {2'd1, 2'd0, 2'd0, 2'd3};
        checks++;
        if (cnt !== exp) begin
            errors++;
            $display("FAIL cnt_basic got %h exp %h", cnt, exp);
        end
        for (int i = 4; i < 6; i++) begin
            @(negedge clk);
            vin = 1'b1;
            sel = seq[i];
        end
        @(negedge clk);
        vin = 1'b0;
        @(negedge clk);
        #1;
        exp = {2'd1, 2'd0, 2'd0, 2'd1};
        checks++;
        if (cnt !== exp) begin
            errors++;
            $display("FAIL cnt_wrap got %h exp %h", cnt, exp);
        end
        @(negedge clk);
        vin = 1'b1;
        sel = 2'd3;
        @(negedge clk);
        vin = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++;
        if (cnt !== '0 || ovalid !== 4'b0000) begin
            errors++;
            $display("FAIL cnt_clr got %h/%b exp 0/0000", cnt, ovalid);
        end
    endtask
`endif

    task automatic test_random();
        beat_t         q[$];
        beat_t         b;
        logic [W-1:0]  ch [4];
        logic [VW-1:0] got, exp;
        logic          has, erdy, dlv;
        int            cm [4];
        logic [4*CW-1:0] ecnt;
        for (int k = 0; k < 4; k++) cm[k] = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            vin = 1'($urandom);
            din = W'($urandom);
            sel = 2'($urandom);
            rdy = 4'($urandom);
`ifdef DEMUX4_CNT_EN
            clr = ($urandom_range(0, 15) == 0);
`endif
            #1;
            has  = (q.size() > 0);
            erdy = !has || rdy[q[0].s];
            for (int k = 0; k < 4; k++) ch[k] = '0;
            if (has) ch[q[0].s] = q[0].d;
            exp = {erdy, has ? 4'(1 << q[0].s) : 4'b0000,
                   ch[0], ch[1], ch[2], ch[3]};
            got = {oready, ovalid, oa, ob, oc, od};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand cyc%0d got %h exp %h", n, got, exp);
            end
`ifdef DEMUX4_CNT_EN
            for (int k = 0; k < 4; k++) ecnt[k*CW +: CW] = CW'(cm[k]);
            checks++;
            if (cnt !== ecnt) begin
                errors++;
                $display("FAIL rand_cnt cyc%0d got %h exp %h", n, cnt, ecnt);
            end
`endif
            dlv = has && rdy[q[0].s];
`ifdef DEMUX4_CNT_EN
            if (clr) begin
                for (int k = 0; k < 4; k++) cm[k] = 0;
            end else if (dlv) begin
                cm[q[0].s] = (cm[q[0].s] + 1) % (1 << CW);
            end
`endif
            if (dlv) void'(q.pop_front());
            if (vin && erdy) begin
                b.d = din;
                b.s = sel;
                q.push_back(b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_reset_mid();
`ifdef DEMUX4_CNT_EN
        test_counters();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux4_reg.md
Name: demux4_reg

Overview:
- 1-to-4 registered demultiplexer: the inverse of the team's 4:1 mux.
- Takes one valid/ready input stream with a 2-bit select and steers each beat to one of four output channels, each with its own valid/ready handshake.
- A single holding register gives 1-cycle latency and full throughput when the selected sink is ready.
- Sits between a producer and four independent consumers.

Parameters:
WIDTH, 8, data width of input and each output channel
CNT_WIDTH, 16, width of each per-channel beat counter (used only with DEMUX4_CNT_EN)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  input beat valid
o_ready  output  1  block can accept input beat this cycle
i_data  input  WIDTH  input beat data
i_sel  input  2  destination: 0->a, 1->b, 2->c, 3->d
o_valid  output  4  per-channel valid; bit k = channel k (a=0 .. d=3)
i_ready  input  4  per-channel sink ready; bit k = channel k
o_a  output  WIDTH  channel a data
o_b  output  WIDTH  channel b data
o_c  output  WIDTH  channel c data
o_d  output  WIDTH  channel d data

Behaviour:
- Clock and reset are fixed: one clock, i_clk; reset i_rst_n is asynchronous and active-low.
- State: full flag, data_q[WIDTH-1:0], sel_q[1:0].
- Reset, applied immediately and asynchronously:
  - full=0, data_q=0, sel_q=0.
  - o_valid=4'b0000, o_a..o_d=0.
  - o_ready is forced 0 while i_rst_n is low.
- o_ready (combinational) = i_rst_n && (!full || i_ready[sel_q]).
  - This is a combinational path from i_ready to o_ready by design.
- Accept: i_valid && o_ready at a rising edge -> data_q<=i_data, sel_q<=i_sel, full<=1.
- Drain: full && i_ready[sel_q] at a rising edge.
  - If there is no simultaneous accept, full<=0.
  - Drain and accept in the same cycle: full stays 1 and the new beat replaces the old one. This gives 1 beat/cycle sustained throughput.
- Outputs:
  - o_valid[k] = full && (sel_q==k).
  - Channel k data = data_q when o_valid[k], else 0.
- Latency: a beat accepted at edge N is visible on its channel after edge N and can drain at edge N+1.
- Head-of-line blocking: a held beat waits only on i_ready[sel_q]. The ready state of the other channels has no effect on it.
- Held data and sel_q are stable while o_valid[k] is high and i_ready[k] is low.
- i_data and i_sel are don't-care when i_valid=0.
- Reset asserted mid-operation: a held beat is discarded and is never delivered.

Optional Feature:
- Macro: DEMUX4_CNT_EN.
- Defined, the block adds two ports:
  - i_cnt_clr, input, 1: synchronous clear of all counters.
  - o_cnt, output, 4*CNT_WIDTH: channel k count at bits [k*CNT_WIDTH +: CNT_WIDTH].
- Counter behaviour:
  - Each counter increments by 1 on every drain to its channel.
  - Counters wrap modulo 2^CNT_WIDTH.
  - Counters reset to 0.
  - i_cnt_clr has priority: clear and drain in the same cycle gives 0, and that drain is not counted.
- Not defined: these ports and the counter logic are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset: hold i_rst_n=0 with i_valid=1 -> o_ready=0, o_valid=4'b0000, o_a..o_d=0. Release reset -> o_ready=1.
2. Routing, i_ready=4'b1111: back-to-back beats 8'h01/sel0, 8'h02/sel1, 8'h03/sel2, 8'h04/sel3 -> on consecutive cycles o_a=1, o_b=2, o_c=3, o_d=4. Exactly one o_valid bit is set, the other outputs are 0, and o_ready stays 1 throughout.
3. Backpressure:
   - Set i_ready=4'b1011 and send 8'h33/sel2 then 8'h44/sel3 -> o_valid=4'b0100 and o_c=8'h33 held, o_ready=0, 8'h44 not accepted.
   - Raise i_ready[2] -> 8'h33 drains and 8'h44 is accepted at the same edge; next cycle o_valid=4'b1000, o_d=8'h44.
4. Reset mid-operation: with 8'h55/sel1 held and i_ready[1]=0, assert i_rst_n=0 between clock edges -> o_valid=0 and o_b=0 immediately. After release, no beat appears.
5. Counters (DEMUX4_CNT_EN, CNT_WIDTH=2):
   - 3 beats to a, 1 beat to d -> cnt a=3, cnt d=1.
   - 2 more beats to a -> cnt a=1 (wrap).
   - Assert i_cnt_clr in the same cycle as a drain to d -> all counts 0.
